// File: rtl/handshake_pkg.sv
// Shared definitions for the elastic handshake units: skid-buffer state encoding
// and a constant clog2 helper for sizing counters from parameters.
package handshake_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/handshake_skid_buffer.sv
// Two-entry skid buffer: in_ready and out_valid both decode the state register only,
// so neither ready nor valid has a combinational path through this block.
module handshake_skid_buffer
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output skid_state_e           dbg_state
);

  skid_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  acc, pop;

  // A transfer on either side happens when valid and ready are both high at the rising edge.
  assign in_ready  = (state_q != SKID_FULL);
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = main_q;
  assign dbg_state = state_q;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (acc) begin
          state_d = SKID_ONE;
          main_d  = in_data;
        end
      end
      SKID_ONE: begin
        if (acc && pop) begin
          main_d = in_data;
        end else if (acc) begin
          state_d = SKID_FULL;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          state_d = SKID_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/handshake_constant_seq.sv
// Constant / arithmetic-sequence source: one value per control token, registered through a
// skid buffer. Define HANDSHAKE_CONSTANT_SEQ_TOKEN_COUNT_EN to add the tok_count port.
module handshake_constant_seq
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned VALUE      = 0,
  parameter int unsigned STEP       = 0,
  parameter int unsigned WRAP_COUNT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  input  logic                  seq_restart,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
`ifdef HANDSHAKE_CONSTANT_SEQ_TOKEN_COUNT_EN
  ,
  output logic [31:0]           tok_count
`endif
);

  localparam int unsigned IDX_W = (clog2(WRAP_COUNT) < 1) ? 1 : clog2(WRAP_COUNT);
  localparam logic [DATA_WIDTH-1:0] VALUE_T  = DATA_WIDTH'(VALUE);
  localparam logic [DATA_WIDTH-1:0] STEP_T   = DATA_WIDTH'(STEP);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'((WRAP_COUNT == 0) ? 0 : WRAP_COUNT - 1);

  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  acc;
  logic                  buf_in_ready;
  skid_state_e           buf_state;

  // Ready is decoded directly from the buffer state register; buf_in_ready carries the same decode.
  assign ctrl_ready = (buf_state != SKID_FULL);
  assign acc        = ctrl_valid & buf_in_ready;

  // Restart wins over advance; an accepted token still carries the pre-restart cur.
  always_comb begin
    cur_d = cur_q;
    idx_d = idx_q;
    if (seq_restart) begin
      cur_d = VALUE_T;
      idx_d = '0;
    end else if (acc) begin
      if ((WRAP_COUNT != 0) && (idx_q == IDX_LAST)) begin
        cur_d = VALUE_T;
        idx_d = '0;
      end else begin
        cur_d = cur_q + STEP_T;
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q <= VALUE_T;
      idx_q <= '0;
    end else begin
      cur_q <= cur_d;
      idx_q <= idx_d;
    end
  end

  handshake_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (ctrl_valid),
    .in_ready (buf_in_ready),
    .in_data  (cur_q),
    .out_valid(outs_valid),
    .out_ready(outs_ready),
    .out_data (outs),
    .dbg_state(buf_state)
  );

`ifdef HANDSHAKE_CONSTANT_SEQ_TOKEN_COUNT_EN
  logic [31:0] tok_q, tok_d;

  always_comb begin
    tok_d = tok_q;
    if (acc && (tok_q != 32'hFFFF_FFFF)) tok_d = tok_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tok_q <= 32'd0;
    else      tok_q <= tok_d;
  end

  assign tok_count = tok_q;
`endif

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Bench for handshake_constant_seq: scenario tasks plus a negedge scoreboard per instance.
module tb_handshake_constant_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         ctrl_valid, ctrl_ready, seq_restart, outs_valid, outs_ready;
  logic [W-1:0] outs;
  logic         ctrl_valid_w, ctrl_ready_w, seq_restart_w, outs_valid_w, outs_ready_w;
  logic [W-1:0] outs_w;
`ifdef HANDSHAKE_CONSTANT_SEQ_TOKEN_COUNT_EN
  logic [31:0]  tok_count, tok_count_w;
`endif

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w_q[$];
  logic [W-1:0] sb_e, sb_ew;
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  handshake_constant_seq #(.DATA_WIDTH(W), .VALUE(8'h10), .STEP(3), .WRAP_COUNT(4)) dut (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .seq_restart(seq_restart), .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready)
`ifdef HANDSHAKE_CONSTANT_SEQ_TOKEN_COUNT_EN
    , .tok_count(tok_count)
`endif
  );

  handshake_constant_seq #(.DATA_WIDTH(W), .VALUE(8'hFE), .STEP(1), .WRAP_COUNT(0)) dut_w (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid_w), .ctrl_ready(ctrl_ready_w),
    .seq_restart(seq_restart_w), .outs(outs_w), .outs_valid(outs_valid_w), .outs_ready(outs_ready_w)
`ifdef HANDSHAKE_CONSTANT_SEQ_TOKEN_COUNT_EN
    , .tok_count(tok_count_w)
`endif
  );

  // Scoreboard: a pop happens at the next rising edge when valid & ready are high at the negedge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (outs_valid && outs_ready) begin
        n_vec = n_vec + 1;
        if (exp_q.size() == 0) begin
          n_err = n_err + 1;
          $display("FAIL sb_main: got %h, required no token", outs);
        end else begin
          sb_e = exp_q.pop_front();
          if (outs !== sb_e) begin
            n_err = n_err + 1;
            $display("FAIL sb_main: got %h, required %h", outs, sb_e);
          end
        end
      end
      if (outs_valid_w && outs_ready_w) begin
        n_vec = n_vec + 1;
        if (exp_w_q.size() == 0) begin
          n_err = n_err + 1;
          $display("FAIL sb_wrap: got %h, required no token", outs_w);
        end else begin
          sb_ew = exp_w_q.pop_front();
          if (outs_w !== sb_ew) begin
            n_err = n_err + 1;
            $display("FAIL sb_wrap: got %h, required %h", outs_w, sb_ew);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_restart();
    ctrl_valid  = 1'b0;
    seq_restart = 1'b1;
    tick();
    seq_restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (6) begin
      ctrl_valid  = 1'($urandom_range(0, 1));
      seq_restart = 1'($urandom_range(0, 1));
      outs_ready  = 1'($urandom_range(0, 1));
      tick();
      n_vec = n_vec + 1;
      if (outs_valid !== 1'b0 || ctrl_ready !== 1'b1 || outs !== 8'h00) begin
        n_err = n_err + 1;
        $display("FAIL reset_hold: valid=%b ready=%b outs=%h, required 0 1 00", outs_valid, ctrl_ready, outs);
      end
    end
    @(negedge clk);
    rst         = 1'b1;
    ctrl_valid  = 1'b1;
    seq_restart = 1'b0;
    outs_ready  = 1'b0;
    exp_q.push_back(8'h10);
    tick();
    n_vec = n_vec + 1;
    if (outs_valid !== 1'b1 || outs !== 8'h10) begin
      n_err = n_err + 1;
      $display("FAIL reset_first_acc: valid=%b outs=%h, required 1 10", outs_valid, outs);
    end
    ctrl_valid = 1'b0;
    outs_ready = 1'b1;
    tick();
    n_vec = n_vec + 1;
    if (outs_valid !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset_drain: valid=%b, required 0", outs_valid);
    end
`ifdef HANDSHAKE_CONSTANT_SEQ_TOKEN_COUNT_EN
    n_vec = n_vec + 1;
    if (tok_count !== 32'd1) begin
      n_err = n_err + 1;
      $display("FAIL reset_tok_count: got %0d, required 1", tok_count);
    end
`endif
  endtask

  task automatic test_streaming();
    logic [W-1:0] tbl[6] = '{8'h10, 8'h13, 8'h16, 8'h19, 8'h10, 8'h13};
    idle_restart();
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    ctrl_valid = 1'b1;
    outs_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec = n_vec + 1;
      if (outs_valid !== 1'b1 || ctrl_ready !== 1'b1) begin
        n_err = n_err + 1;
        $display("FAIL stream_bubble: cycle %0d valid=%b ready=%b, required 1 1", i, outs_valid, ctrl_ready);
      end
    end
    ctrl_valid = 1'b0;
    tick();
    n_vec = n_vec + 1;
    if (outs_valid !== 1'b0 || exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL stream_drain: valid=%b pending=%0d, required 0 0", outs_valid, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    idle_restart();
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h16);
    ctrl_valid = 1'b1;
    outs_ready = 1'b0;
    tick();
    tick();
    n_vec = n_vec + 1;
    if (ctrl_ready !== 1'b0 || outs_valid !== 1'b1 || outs !== 8'h10) begin
      n_err = n_err + 1;
      $display("FAIL bp_full: ready=%b valid=%b outs=%h, required 0 1 10", ctrl_ready, outs_valid, outs);
    end
    tick();
    n_vec = n_vec + 1;
    if (ctrl_ready !== 1'b0 || outs_valid !== 1'b1 || outs !== 8'h10) begin
      n_err = n_err + 1;
      $display("FAIL bp_hold: ready=%b valid=%b outs=%h, required 0 1 10", ctrl_ready, outs_valid, outs);
    end
    outs_ready = 1'b1;
    tick();
    n_vec = n_vec + 1;
    if (ctrl_ready !== 1'b1 || outs !== 8'h13) begin
      n_err = n_err + 1;
      $display("FAIL bp_release: ready=%b outs=%h, required 1 13", ctrl_ready, outs);
    end
    tick();
    ctrl_valid = 1'b0;
    tick();
    n_vec = n_vec + 1;
    if (outs_valid !== 1'b0 || exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL bp_drain: valid=%b pending=%0d, required 0 0", outs_valid, exp_q.size());
    end
  endtask

  task automatic test_wrap_arith();
    logic [W-1:0] tbl[5] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    foreach (tbl[i]) exp_w_q.push_back(tbl[i]);
    ctrl_valid_w = 1'b1;
    outs_ready_w = 1'b1;
    repeat (5) tick();
    ctrl_valid_w = 1'b0;
    tick();
    n_vec = n_vec + 1;
    if (outs_valid_w !== 1'b0 || exp_w_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL wrap_drain: valid=%b pending=%0d, required 0 0", outs_valid_w, exp_w_q.size());
    end
`ifdef HANDSHAKE_CONSTANT_SEQ_TOKEN_COUNT_EN
    n_vec = n_vec + 1;
    if (tok_count_w !== 32'd5) begin
      n_err = n_err + 1;
      $display("FAIL wrap_tok_count: got %0d, required 5", tok_count_w);
    end
`endif
  endtask

  task automatic test_restart();
    logic [W-1:0] tbl[5] = '{8'h10, 8'h13, 8'h16, 8'h10, 8'h13};
    idle_restart();
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    ctrl_valid = 1'b1;
    outs_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      seq_restart = (i == 2);
      tick();
    end
    seq_restart = 1'b0;
    ctrl_valid  = 1'b0;
    tick();
    idle_restart();
    exp_q.push_back(8'h10);
    ctrl_valid = 1'b1;
    tick();
    ctrl_valid = 1'b0;
    tick();
    n_vec = n_vec + 1;
    if (exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL restart_drain: pending=%0d, required 0", exp_q.size());
    end
`ifdef HANDSHAKE_CONSTANT_SEQ_TOKEN_COUNT_EN
    n_vec = n_vec + 1;
    if (tok_count !== 32'd16) begin
      n_err = n_err + 1;
      $display("FAIL restart_tok_count: got %0d, required 16", tok_count);
    end
`endif
  endtask

  task automatic test_reset_mid_full();
    idle_restart();
    ctrl_valid = 1'b1;
    outs_ready = 1'b0;
    tick();
    tick();
    n_vec = n_vec + 1;
    if (ctrl_ready !== 1'b0 || outs_valid !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL midfull_fill: ready=%b valid=%b, required 0 1", ctrl_ready, outs_valid);
    end
    ctrl_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_vec = n_vec + 1;
    if (outs_valid !== 1'b0 || ctrl_ready !== 1'b1 || outs !== 8'h00) begin
      n_err = n_err + 1;
      $display("FAIL midfull_async: valid=%b ready=%b outs=%h, required 0 1 00", outs_valid, ctrl_ready, outs);
    end
`ifdef HANDSHAKE_CONSTANT_SEQ_TOKEN_COUNT_EN
    n_vec = n_vec + 1;
    if (tok_count !== 32'd0) begin
      n_err = n_err + 1;
      $display("FAIL midfull_tok_clear: got %0d, required 0", tok_count);
    end
`endif
    @(negedge clk);
    rst        = 1'b1;
    ctrl_valid = 1'b1;
    outs_ready = 1'b1;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h13);
    tick();
    tick();
    ctrl_valid = 1'b0;
    tick();
    n_vec = n_vec + 1;
    if (outs_valid !== 1'b0 || exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL midfull_after: valid=%b pending=%0d, required 0 0", outs_valid, exp_q.size());
    end
`ifdef HANDSHAKE_CONSTANT_SEQ_TOKEN_COUNT_EN
    n_vec = n_vec + 1;
    if (tok_count !== 32'd2) begin
      n_err = n_err + 1;
      $display("FAIL midfull_tok_count: got %0d, required 2", tok_count);
    end
`endif
  endtask

  initial begin
    rst           = 1'b0;
    ctrl_valid    = 1'b0;
    seq_restart   = 1'b0;
    outs_ready    = 1'b0;
    ctrl_valid_w  = 1'b0;
    seq_restart_w = 1'b0;
    outs_ready_w  = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_wrap_arith();
    test_restart();
    test_reset_mid_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err = n_err + 1;
    $display("FAIL watchdog: run exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/handshake_constant_seq.md
Name: handshake_constant_seq

Overview:
Parametrised successor to the dataflow handshake constant. It emits a constant, or an arithmetic sequence starting at a constant, once per control token. The output is registered through a 2-entry skid buffer, so no combinational path runs from outs_ready to ctrl_ready or from ctrl_valid to outs_valid. It sits between a control-token producer and a data consumer in generated elastic dataflow circuits.

Parameters:
- DATA_WIDTH, 32, width of outs.
- VALUE, 0, first (and, when STEP=0, only) emitted value; truncated to DATA_WIDTH.
- STEP, 0, added to the value after each accepted token; modulo 2^DATA_WIDTH.
- WRAP_COUNT, 0, number of tokens after which the sequence returns to VALUE; 0 means never wrap.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- ctrl_valid  in  1  control token valid.
- ctrl_ready  out  1  control token ready.
- seq_restart  in  1  synchronous; next generated value reverts to VALUE.
- outs  out  DATA_WIDTH  output data.
- outs_valid  out  1  output valid.
- outs_ready  in  1  output ready.
- tok_count  out  32  accepted-token count; present only with the feature macro.

Behaviour:
- Accept event: acc = ctrl_valid & ctrl_ready. Pop event: pop = outs_valid & outs_ready.
- Generator registers:
  - cur (DATA_WIDTH bits), reset VALUE.
  - idx (clog2(WRAP_COUNT) bits, min 1), reset 0.
- On acc:
  - cur is written into the buffer.
  - If seq_restart: cur<=VALUE, idx<=0.
  - Else if WRAP_COUNT!=0 and idx==WRAP_COUNT-1: cur<=VALUE, idx<=0.
  - Else: cur<=cur+STEP (mod 2^DATA_WIDTH), idx<=idx+1.
- seq_restart without acc: cur<=VALUE, idx<=0.
- seq_restart with acc: the accepted token still carries the old cur; restart applies to the next token.
- Skid buffer: main and skid data registers, state in {EMPTY, ONE, FULL}.
  - EMPTY: acc -> ONE, main<=cur.
  - ONE, acc and pop: stay ONE, main<=cur.
  - ONE, acc without pop: -> FULL, skid<=cur.
  - ONE, pop without acc: -> EMPTY.
  - FULL: no acc possible; pop -> ONE, main<=skid.
- Output decode:
  - ctrl_ready = (state!=FULL), decoded from the state register only.
  - outs_valid = (state!=EMPTY).
  - outs = main.
- Latency: 1 cycle from acc to outs_valid. Throughput: 1 token/cycle when outs_ready=1.
- Stability: while outs_valid & !outs_ready, outs and outs_valid hold. Tokens are never dropped or duplicated. Order is preserved.
- Reset, applied asynchronously at any time including mid-stream:
  - state=EMPTY, so outs_valid=0 and ctrl_ready=1.
  - main=0, skid=0, so outs=0.
  - cur=VALUE, idx=0, tok_count=0.
  - Buffered tokens are discarded.
- Reset release: first acc is allowed on the first clk edge after rst rises.
- STEP=0 and WRAP_COUNT=0: pure constant source with a registered output.

Optional Feature:
- Macro: HANDSHAKE_CONSTANT_SEQ_TOKEN_COUNT_EN.
- Defined:
  - tok_count port exists.
  - Increments on every acc.
  - Saturates at 32'hFFFFFFFF.
  - Unaffected by seq_restart.
  - Reset to 0.
- Undefined: port and counter are absent, with no other change in behaviour.

Decomposition:
- Package handshake_pkg:
  - state encodings SKID_EMPTY=2'd0, SKID_ONE=2'd1, SKID_FULL=2'd2;
  - helper constant function for clog2.
- Sub-module handshake_skid_buffer (DATA_WIDTH; in_valid/in_ready/in_data -> out_valid/out_ready/out_data), reusable by other handshake units.
- Top level holds the generator, the restart/wrap logic and the optional counter.

Test Plan:
All tests use DATA_WIDTH=8, VALUE=8'h10, STEP=3, WRAP_COUNT=4 unless noted.
- Reset: hold rst=0 with random inputs -> outs_valid=0, ctrl_ready=1, outs=8'h00. Release -> first token accepted on the next edge.
- Streaming: ctrl_valid=1, outs_ready=1 for 6 cycles -> outs 10,13,16,19,10,13, each valid one cycle after its acc, with no bubbles.
- Backpressure: outs_ready=0, ctrl_valid=1 -> two acc, then ctrl_ready=0. outs holds 10. Raise outs_ready -> 10,13,16 in order, no loss.
- Wrap-around arithmetic: VALUE=8'hFE, STEP=1, WRAP_COUNT=0, five tokens -> FE,FF,00,01,02.
- Restart: seq_restart=1 coincident with the 3rd acc -> outs 10,13,16,10,13. Restart alone on an idle cycle -> next token 10.
- Reset mid-FULL: fill the buffer, then pulse rst=0 asynchronously -> outs_valid drops immediately, ctrl_ready=1. The next tokens are 10,13, and tok_count restarts at 0 (feature on).
